// File: rtl/move_input_conditioner.sv
// Board front end: synchronises, debounces and one-shots the two player buttons, captures the
// position switches at each accepted press and arbitrates same-cycle presses in favour of P1.
module move_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn1_raw,
   input  logic       btn2_raw,
   input  logic [3:0] sw1_raw,
   input  logic [3:0] sw2_raw,
   output logic       player1,
   output logic       player2,
   output logic [3:0] player1_posiciones,
   output logic [3:0] player2_posiciones,
   output logic       press_dropped
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StArmed, StHeld} btn_state_e;

   // Two-flop synchronisers
   logic       btn1_s1_q, btn1_s2_q;
   logic       btn2_s1_q, btn2_s2_q;
   logic [3:0] sw1_s1_q, sw1_s2_q;
   logic [3:0] sw2_s1_q, sw2_s2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn1_s1_q <= 1'b0;
         btn1_s2_q <= 1'b0;
         btn2_s1_q <= 1'b0;
         btn2_s2_q <= 1'b0;
         sw1_s1_q  <= '0;
         sw1_s2_q  <= '0;
         sw2_s1_q  <= '0;
         sw2_s2_q  <= '0;
      end else begin
         btn1_s1_q <= btn1_raw;
         btn1_s2_q <= btn1_s1_q;
         btn2_s1_q <= btn2_raw;
         btn2_s2_q <= btn2_s1_q;
         sw1_s1_q  <= sw1_raw;
         sw1_s2_q  <= sw1_s1_q;
         sw2_s1_q  <= sw2_raw;
         sw2_s2_q  <= sw2_s1_q;
      end
   end

   // Debounce: stable level flips only after DEBOUNCE_CYCLES consecutive differing samples
   logic             stable1_q, stable1_d;
   logic             stable2_q, stable2_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic [CNT_W-1:0] cnt2_q, cnt2_d;

   always_comb begin
      stable1_d = stable1_q;
      cnt1_d    = '0;
      if (btn1_s2_q != stable1_q) begin
         if (cnt1_q == CntLast) begin
            stable1_d = ~stable1_q;
         end else begin
            cnt1_d = cnt1_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      stable2_d = stable2_q;
      cnt2_d    = '0;
      if (btn2_s2_q != stable2_q) begin
         if (cnt2_q == CntLast) begin
            stable2_d = ~stable2_q;
         end else begin
            cnt2_d = cnt2_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable1_q <= 1'b0;
         stable2_q <= 1'b0;
         cnt1_q    <= '0;
         cnt2_q    <= '0;
      end else begin
         stable1_q <= stable1_d;
         stable2_q <= stable2_d;
         cnt1_q    <= cnt1_d;
         cnt2_q    <= cnt2_d;
      end
   end

   // Per-player one-shot FSMs: a press arms for exactly one cycle, then waits for release
   btn_state_e state1_q, state1_d;
   btn_state_e state2_q, state2_d;

   always_comb begin
      state1_d = state1_q;
      unique case (state1_q)
         StIdle:  if (stable1_q) state1_d = StArmed;
         StArmed: state1_d = StHeld;
         StHeld:  if (!stable1_q) state1_d = StIdle;
         default: state1_d = StIdle;
      endcase
   end

   always_comb begin
      state2_d = state2_q;
      unique case (state2_q)
         StIdle:  if (stable2_q) state2_d = StArmed;
         StArmed: state2_d = StHeld;
         StHeld:  if (!stable2_q) state2_d = StIdle;
         default: state2_d = StIdle;
      endcase
   end

   // Arbitration and registered outputs; a losing P2 press is consumed, not deferred
   logic       arm1, arm2, accept2;
   logic       player1_q, player1_d;
   logic       player2_q, player2_d;
   logic       dropped_q, dropped_d;
   logic [3:0] pos1_q, pos1_d;
   logic [3:0] pos2_q, pos2_d;

   always_comb begin
      arm1      = (state1_q == StArmed);
      arm2      = (state2_q == StArmed);
      accept2   = arm2 & ~arm1;
      player1_d = arm1;
      player2_d = accept2;
      dropped_d = arm1 & arm2;
      pos1_d    = arm1 ? sw1_s2_q : pos1_q;
      pos2_d    = accept2 ? sw2_s2_q : pos2_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state1_q  <= StIdle;
         state2_q  <= StIdle;
         player1_q <= 1'b0;
         player2_q <= 1'b0;
         dropped_q <= 1'b0;
         pos1_q    <= '0;
         pos2_q    <= '0;
      end else begin
         state1_q  <= state1_d;
         state2_q  <= state2_d;
         player1_q <= player1_d;
         player2_q <= player2_d;
         dropped_q <= dropped_d;
         pos1_q    <= pos1_d;
         pos2_q    <= pos2_d;
      end
   end

   assign player1            = player1_q;
   assign player2            = player2_q;
   assign press_dropped      = dropped_q;
   assign player1_posiciones = pos1_q;
   assign player2_posiciones = pos2_q;

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner: stimulus table, hand-written corner sequences and random
// traffic, all compared every cycle against a history-window reference model.
module tb_move_input_conditioner;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn1_raw, btn2_raw;
   logic [3:0] sw1_raw, sw2_raw;
   logic       player1, player2, press_dropped;
   logic [3:0] player1_posiciones, player2_posiciones;

   always #5 clk = ~clk;

   move_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .btn1_raw          (btn1_raw),
      .btn2_raw          (btn2_raw),
      .sw1_raw           (sw1_raw),
      .sw2_raw           (sw2_raw),
      .player1           (player1),
      .player2           (player2),
      .player1_posiciones(player1_posiciones),
      .player2_posiciones(player2_posiciones),
      .press_dropped     (press_dropped)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int c1, c2, cd;
   int cyc = 0;

   // Reference model: raw {btn,sw} history per player; debounced level flips when the last D
   // synchronised samples (raw delayed by two edges) all disagree with it.
   logic [4:0] hist1[$];
   logic [4:0] hist2[$];
   logic [1:0] m_stable, m_r1, m_r2;
   logic [3:0] m_pos_r1[2];
   logic [3:0] m_pos_r2[2];
   logic       e_p1, e_p2, e_drop;
   logic [3:0] e_pos1, e_pos2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      hist1.delete();
      hist2.delete();
      for (int i = 0; i < D + 2; i++) begin
         hist1.push_back(5'd0);
         hist2.push_back(5'd0);
      end
      m_stable = '0;
      m_r1     = '0;
      m_r2     = '0;
      for (int p = 0; p < 2; p++) begin
         m_pos_r1[p] = '0;
         m_pos_r2[p] = '0;
      end
      e_p1   = 1'b0;
      e_p2   = 1'b0;
      e_drop = 1'b0;
      e_pos1 = '0;
      e_pos2 = '0;
   endtask

   function automatic logic window_flips(input logic [4:0] q[$], input logic st);
      for (int j = 0; j < D; j++) begin
         if (q[q.size() - 2 - j][4] == st) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge();
      logic [1:0] flip, rise, fire;
      if (!reset) return;
      flip[0] = window_flips(hist1, m_stable[0]);
      flip[1] = window_flips(hist2, m_stable[1]);
      rise    = flip & ~m_stable;
      m_stable = m_stable ^ flip;
      fire = m_r2;
      // A press becomes a strobe two edges after its debounced rise
      e_p1   = fire[0];
      e_p2   = fire[1] & ~fire[0];
      e_drop = fire[0] & fire[1];
      if (fire[0]) e_pos1 = m_pos_r2[0];
      if (fire[1] && !fire[0]) e_pos2 = m_pos_r2[1];
      m_r2        = m_r1;
      m_pos_r2[0] = m_pos_r1[0];
      m_pos_r2[1] = m_pos_r1[1];
      m_r1        = rise;
      m_pos_r1[0] = sw1_raw;
      m_pos_r1[1] = sw2_raw;
      hist1.push_back({btn1_raw, sw1_raw});
      hist2.push_back({btn2_raw, sw2_raw});
      void'(hist1.pop_front());
      void'(hist2.pop_front());
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check($sformatf("cycle%0d", cyc),
            {21'd0, player1, player2, press_dropped, player1_posiciones, player2_posiciones},
            {21'd0, e_p1, e_p2, e_drop, e_pos1, e_pos2});
      if (player1) c1++;
      if (player2) c2++;
      if (press_dropped) cd++;
   endtask

   task automatic async_reset(input string name);
      reset = 1'b0;
      #1;
      model_reset();
      check(name, {21'd0, player1, player2, press_dropped, player1_posiciones,
            player2_posiciones}, 32'd0);
   endtask

   task automatic measure_p1(input string name);
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      btn1_raw = 1'b1;
      while (!seen && n < 40) begin
         step();
         n++;
         if (player1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || n < D + 3 || n > D + 5) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles (seen=%0d), required %0d..%0d",
                  name, n, seen, D + 3, D + 5);
      end
   endtask

   typedef struct {
      logic       b1, b2;
      logic [3:0] s1, s2;
      int         ncyc;
      int         ep1, ep2, ed;
      logic [3:0] epos1, epos2;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 4'd0, 4'd0, 10,  0, 0, 0, 4'd0, 4'd0};
      tbl[1]  = '{1'b1, 1'b0, 4'd5, 4'd0, 100, 1, 0, 0, 4'd5, 4'd0};
      tbl[2]  = '{1'b0, 1'b0, 4'd3, 4'd0, 20,  0, 0, 0, 4'd5, 4'd0};
      tbl[3]  = '{1'b1, 1'b0, 4'd3, 4'd0, 20,  1, 0, 0, 4'd3, 4'd0};
      tbl[4]  = '{1'b0, 1'b0, 4'd7, 4'd0, 20,  0, 0, 0, 4'd3, 4'd0};
      tbl[5]  = '{1'b1, 1'b0, 4'd7, 4'd0, 20,  1, 0, 0, 4'd7, 4'd0};
      tbl[6]  = '{1'b0, 1'b0, 4'd1, 4'd0, 20,  0, 0, 0, 4'd7, 4'd0};
      tbl[7]  = '{1'b1, 1'b0, 4'd1, 4'd0, 3,   0, 0, 0, 4'd7, 4'd0};
      tbl[8]  = '{1'b0, 1'b0, 4'd1, 4'd0, 20,  0, 0, 0, 4'd7, 4'd0};
      tbl[9]  = '{1'b1, 1'b1, 4'd2, 4'd6, 20,  1, 0, 1, 4'd2, 4'd0};
      tbl[10] = '{1'b0, 1'b0, 4'd2, 4'd6, 20,  0, 0, 0, 4'd2, 4'd0};
      tbl[11] = '{1'b0, 1'b1, 4'd2, 4'd9, 20,  0, 1, 0, 4'd2, 4'd9};

      reset    = 1'b0;
      btn1_raw = 1'b0;
      btn2_raw = 1'b0;
      sw1_raw  = '0;
      sw2_raw  = '0;
      model_reset();
      #1;
      check("reset_state", {21'd0, player1, player2, press_dropped, player1_posiciones,
            player2_posiciones}, 32'd0);
      repeat (3) step();
      reset = 1'b1;

      for (int r = 0; r < 12; r++) begin
         btn1_raw = tbl[r].b1;
         btn2_raw = tbl[r].b2;
         sw1_raw  = tbl[r].s1;
         sw2_raw  = tbl[r].s2;
         c1 = 0; c2 = 0; cd = 0;
         repeat (tbl[r].ncyc) step();
         check($sformatf("row%0d_p1_pulses", r), c1, tbl[r].ep1);
         check($sformatf("row%0d_p2_pulses", r), c2, tbl[r].ep2);
         check($sformatf("row%0d_dropped", r), cd, tbl[r].ed);
         check($sformatf("row%0d_pos1", r), player1_posiciones, tbl[r].epos1);
         check($sformatf("row%0d_pos2", r), player2_posiciones, tbl[r].epos2);
      end
      btn2_raw = 1'b0;
      repeat (20) step();

      // Clean press latency, then no repeat while held
      sw1_raw = 4'd5;
      measure_p1("clean_press");
      check("clean_press_pos", player1_posiciones, 4'd5);
      c1 = 0;
      repeat (100) step();
      check("held_no_repeat", c1, 0);
      btn1_raw = 1'b0;
      repeat (20) step();

      // Bouncing button 2, then a solid hold
      c2 = 0;
      sw2_raw = 4'd4;
      for (int i = 0; i < 20; i++) begin
         btn2_raw = ((i / 2) % 2) == 0;
         step();
      end
      check("bounce_no_strobe", c2, 0);
      btn2_raw = 1'b1;
      repeat (30) step();
      check("bounce_then_one", c2, 1);
      check("bounce_pos2", player2_posiciones, 4'd4);
      btn2_raw = 1'b0;
      repeat (20) step();

      // Reset mid-debounce, button still held afterwards
      sw1_raw  = 4'd8;
      btn1_raw = 1'b1;
      repeat (4) step();
      async_reset("reset_mid_debounce");
      c1 = 0;
      repeat (3) step();
      check("no_pulse_in_reset", c1, 0);
      reset = 1'b1;
      measure_p1("press_after_reset");
      check("pos_after_reset", player1_posiciones, 4'd8);

      // Reset while held
      repeat (10) step();
      async_reset("reset_mid_held");
      repeat (3) step();
      reset = 1'b1;
      measure_p1("held_after_reset");
      c1 = 0;
      repeat (30) step();
      check("held_after_reset_once", c1, 0);
      btn1_raw = 1'b0;
      repeat (20) step();

      // Random traffic against the model
      for (int s = 0; s < 400; s++) begin
         int len;
         btn1_raw = 1'($urandom_range(0, 1));
         btn2_raw = ($urandom_range(0, 3) == 0) ? btn1_raw : 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) sw1_raw = 4'($urandom);
         if ($urandom_range(0, 2) == 0) sw2_raw = 4'($urandom);
         len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
         if ($urandom_range(0, 39) == 0) begin
            async_reset("random_reset");
            repeat (2) step();
            reset = 1'b1;
         end
         repeat (len) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Upstream front end for the tic-tac-toe core. Takes the raw player push-buttons and 4-bit position switches from the board.
- Produces clean single-cycle `player1`/`player2` move strobes, each paired with a position code held stable. These feed the core's `player1`/`player2` and `player1_posiciones`/`player2_posiciones` inputs.
- Handles per-input synchronisation, debounce, one-shot edge detection, position capture and same-cycle arbitration.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised button level must differ from its stable value before the stable value flips (≥2).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn1_raw  input  1  raw player-1 move button, active-high, asynchronous, bouncy.
- btn2_raw  input  1  raw player-2 move button, same as above.
- sw1_raw  input  4  raw player-1 position switches, asynchronous.
- sw2_raw  input  4  raw player-2 position switches, asynchronous.
- player1  output  1  one-cycle move strobe, player 1.
- player2  output  1  one-cycle move strobe, player 2.
- player1_posiciones  output  4  position code captured at player-1's last accepted press.
- player2_posiciones  output  4  position code captured at player-2's last accepted press.
- press_dropped  output  1  one-cycle flag: a player-2 press was discarded by arbitration.

Behaviour:
- Reset (reset=0, async): all outputs 0; synchronisers, stable levels and counters 0; both button FSMs go to IDLE. Release is sampled on the next clk edge.
- Synchronisers: two flops each on btn1_raw, btn2_raw, sw1_raw[3:0] and sw2_raw[3:0]. Only synchronised values are used downstream of this stage.
- Debounce, per button: counter increments each cycle the synced level ≠ stable level, and clears to 0 whenever they are equal. When the count reaches DEBOUNCE_CYCLES-1 with the levels still differing, stable flips on that edge and the counter clears. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Button FSM, per player. States: IDLE, ARMED, HELD.
  - IDLE: wait for the stable level to rise; go to ARMED.
  - ARMED: lasts exactly one cycle and requests a move; go to HELD.
  - HELD: wait for the stable level to fall; go to IDLE.
  - No further request is possible until release is debounced, so holding a button never repeats.
- Request output: on the edge after ARMED, `playerN` is 1 for exactly one cycle. On that same edge, `playerN_posiciones` loads the synchronised switch value sampled in the ARMED cycle.
- Position hold: `playerN_posiciones` changes only on accepted presses. Switch movement at any other time is ignored.
- Latency: a clean raw rising edge to `playerN`=1 takes 2 (sync) + DEBOUNCE_CYCLES + 1 (ARMED) + 1 (output reg) cycles, with ±1 cycle of sampling uncertainty.
- Arbitration: if both FSMs are in ARMED in the same cycle, player 1 is accepted.
  - Player 2's press is consumed: its FSM still goes to HELD, and there is no `player2` strobe and no position update.
  - `press_dropped` pulses 1 cycle, aligned with the `player1` strobe.
  - `player1` and `player2` are never high together.
- Codes 9–15 pass through unmodified; legality is checked downstream.
- Turn order is not enforced here; the core's FSM controller owns it.
- Reset mid-press: all state clears immediately. If the button is still held after release of reset, it is treated as a fresh press once debounced, producing one strobe.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: hold btn1_raw=1 with sw1_raw=4'd5 → exactly one `player1` pulse 8±1 cycles after the edge, with player1_posiciones=5 in that cycle. No second pulse while held for 100 cycles.
- Bounce rejection: toggle btn2_raw 1/0 every 2 cycles for 20 cycles, then hold 1 → no strobe during the toggling, then exactly one `player2` pulse.
- Position hold: after an accepted press with sw1_raw=4'd3, change sw1_raw to 4'd7 without pressing → player1_posiciones stays 3. The next press loads 7.
- Simultaneous: raise both buttons on the same cycle (sw1=2, sw2=6) → `player1` pulse with code 2 and `press_dropped`=1 on that cycle. No `player2` pulse; player2_posiciones unchanged.
- Async reset: assert reset=0 mid-debounce and mid-HELD → all outputs 0 immediately, with no pulse during reset. Button still held after reset releases → one pulse after 8±1 cycles.
- Short glitch: a 3-cycle btn1_raw high pulse → no `player1` strobe.
